instruction_fetch_queue: RTL and testbench

Parametrised successor to the single-slot fetch stage. It sits between the instruction memory port and decode, and owns the fetch PC. It issues at most one outstanding memory request, buffers returned instructions in a DEPTH-entry prefetch FIFO, and presents them to decode with a valid/ready handshake. A PC redirect flushes the FIFO and discards any in-flight response.

---
 rtl/instruction_fetch_queue.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, keeps at most one instruction-memory request
// outstanding and buffers responses in a DEPTH-entry prefetch FIFO for decode.
module instruction_fetch_queue #(
   parameter int unsigned          PC_WIDTH = 32,
   parameter int unsigned          IWIDTH   = 32,
   parameter int unsigned          DEPTH    = 4,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
   parameter int unsigned          PC_STEP  = 4
) (
   input  logic                       f_clk,
   input  logic                       f_rst,
   input  logic                       f_i_ce,
   input  logic                       f_i_change_pc,
   input  logic [PC_WIDTH-1:0]        f_i_pc,
   output logic                       f_o_mem_req,
   output logic [PC_WIDTH-1:0]        f_o_mem_addr,
   input  logic                       f_i_mem_ack,
   input  logic [IWIDTH-1:0]          f_i_mem_instr,
   output logic                       f_o_ce,
   output logic [IWIDTH-1:0]          f_o_instr,
   output logic [PC_WIDTH-1:0]        f_o_pc,
   input  logic                       f_i_ready,
   output logic [$clog2(DEPTH):0]     f_o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t               state;
   logic                 req;
   logic [PC_WIDTH-1:0]  req_addr;
   logic [PC_WIDTH-1:0]  fetch_pc;
   logic [IWIDTH-1:0]    fifo_instr [DEPTH];
   logic [PC_WIDTH-1:0]  fifo_pc    [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [CW-1:0]        count;

   logic                 redirect;
   logic                 acked;
   logic                 push;
   logic                 pop;
   logic                 issue;
   logic [CW-1:0]        count_n;
   logic [PC_WIDTH-1:0]  issue_addr;

   // Reservation uses the post-edge occupancy, so an ack+pop can free the slot
   // for a back-to-back request on the same edge.
   always_comb begin
      redirect   = f_i_ce & f_i_change_pc;
      acked      = f_i_mem_ack & (state != S_IDLE);
      push       = f_i_mem_ack & (state == S_WAIT) & ~redirect;
      pop        = f_i_ce & ~redirect & (count != '0) & f_i_ready;
      count_n    = redirect ? '0 : (count + CW'(push) - CW'(pop));
      issue      = f_i_ce
                 & ((state == S_IDLE) | ((state == S_WAIT) & f_i_mem_ack))
                 & (count_n < CW'(DEPTH));
      issue_addr = redirect ? f_i_pc : fetch_pc;
   end

   always_ff @(posedge f_clk or negedge f_rst) begin
      if (!f_rst) begin
         state    <= S_IDLE;
         req      <= 1'b0;
         req_addr <= '0;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else begin
         count <= count_n;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) begin
               fifo_instr[wr_ptr] <= f_i_mem_instr;
               fifo_pc[wr_ptr]    <= req_addr;
               wr_ptr             <= wr_ptr + AW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
         end

         if (issue) begin
            req      <= 1'b1;
            req_addr <= issue_addr;
            fetch_pc <= issue_addr + PC_WIDTH'(PC_STEP);
         end else begin
            if (acked)
               req <= 1'b0;
            if (redirect)
               fetch_pc <= f_i_pc;
         end

         case (state)
            S_IDLE: if (issue) state <= S_WAIT;
            S_WAIT: begin
               if (f_i_mem_ack)
                  state <= issue ? S_WAIT : S_IDLE;
               else if (redirect)
                  state <= S_DROP;
            end
            S_DROP: if (f_i_mem_ack) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign f_o_mem_req  = req;
   assign f_o_mem_addr = req_addr;
   assign f_o_ce       = (count != '0);
   assign f_o_instr    = fifo_instr[rd_ptr];
   assign f_o_pc       = fifo_pc[rd_ptr];
   assign f_o_count    = count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomised bench for instruction_fetch_queue against a queue-based model of
// the fetch PC, outstanding request and prefetch buffer.
module tb_instruction_fetch_queue;

   localparam int unsigned          DEPTH    = 4;
   localparam logic [31:0]          RESET_PC = 32'h0000_0100;

   logic        f_clk;
   logic        f_rst;
   logic        f_i_ce;
   logic        f_i_change_pc;
   logic [31:0] f_i_pc;
   logic        f_o_mem_req;
   logic [31:0] f_o_mem_addr;
   logic        f_i_mem_ack;
   logic [31:0] f_i_mem_instr;
   logic        f_o_ce;
   logic [31:0] f_o_instr;
   logic [31:0] f_o_pc;
   logic        f_i_ready;
   logic [2:0]  f_o_count;

   instruction_fetch_queue #(
      .PC_WIDTH (32),
      .IWIDTH   (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .PC_STEP  (4)
   ) dut (
      .f_clk         (f_clk),
      .f_rst         (f_rst),
      .f_i_ce        (f_i_ce),
      .f_i_change_pc (f_i_change_pc),
      .f_i_pc        (f_i_pc),
      .f_o_mem_req   (f_o_mem_req),
      .f_o_mem_addr  (f_o_mem_addr),
      .f_i_mem_ack   (f_i_mem_ack),
      .f_i_mem_instr (f_i_mem_instr),
      .f_o_ce        (f_o_ce),
      .f_o_instr     (f_o_instr),
      .f_o_pc        (f_o_pc),
      .f_i_ready     (f_i_ready),
      .f_o_count     (f_o_count)
   );

   initial f_clk = 1'b0;
   always #5 f_clk = ~f_clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      q[$];
   bit          m_busy;     // a request is outstanding at the memory
   bit          m_discard;  // its response must be thrown away
   logic [31:0] m_fetch;
   logic [31:0] m_addr;

   task automatic model_reset();
      q.delete();
      m_busy    = 1'b0;
      m_discard = 1'b0;
      m_fetch   = RESET_PC;
      m_addr    = '0;
   endtask

   task automatic check_model(input string pfx);
      check_eq({pfx, "_req"}, 64'(f_o_mem_req), 64'(m_busy));
      if (m_busy)
         check_eq({pfx, "_addr"}, 64'(f_o_mem_addr), 64'(m_addr));
      check_eq({pfx, "_ce"}, 64'(f_o_ce), 64'(q.size() != 0));
      check_eq({pfx, "_count"}, 64'(f_o_count), 64'(q.size()));
      if (q.size() != 0) begin
         check_eq({pfx, "_pc"}, 64'(f_o_pc), 64'(q[0].pc));
         check_eq({pfx, "_instr"}, 64'(f_o_instr), 64'(q[0].instr));
      end
   endtask

   task automatic check_zero(input string pfx);
      check_eq({pfx, "_req"},   64'(f_o_mem_req),  64'd0);
      check_eq({pfx, "_addr"},  64'(f_o_mem_addr), 64'd0);
      check_eq({pfx, "_ce"},    64'(f_o_ce),       64'd0);
      check_eq({pfx, "_instr"}, 64'(f_o_instr),    64'd0);
      check_eq({pfx, "_pc"},    64'(f_o_pc),       64'd0);
      check_eq({pfx, "_count"}, 64'(f_o_count),    64'd0);
   endtask

   // Called just after a falling edge: drive, predict the next rising edge, check.
   task automatic step(input bit ce, input bit chg, input logic [31:0] pc,
                       input bit rdy, input bit ack);
      logic [31:0] instr;
      bit redirect, took_ack, was_keep, can_issue;
      instr         = $urandom;
      f_i_ce        = ce;
      f_i_change_pc = chg;
      f_i_pc        = pc;
      f_i_ready     = rdy;
      f_i_mem_ack   = ack;
      f_i_mem_instr = instr;

      redirect = ce && chg;
      took_ack = ack && m_busy;
      was_keep = m_busy && !m_discard;
      if (redirect)
         q.delete();
      else if (ce && rdy && q.size() != 0)
         void'(q.pop_front());
      if (took_ack && was_keep && !redirect)
         q.push_back('{pc: m_addr, instr: instr});
      can_issue = ce && (!m_busy || (took_ack && was_keep)) && (q.size() < DEPTH);
      if (took_ack) begin
         m_busy    = 1'b0;
         m_discard = 1'b0;
      end else if (redirect && m_busy) begin
         m_discard = 1'b1;
      end
      if (can_issue) begin
         m_addr  = redirect ? pc : m_fetch;
         m_fetch = m_addr + 32'd4;
         m_busy  = 1'b1;
      end else if (redirect) begin
         m_fetch = pc;
      end

      @(posedge f_clk);
      @(negedge f_clk);
      check_model("cyc");
   endtask

   typedef struct {
      int n;
      int p_ce;
      int p_chg;
      int p_rdy;
      int p_ack;
   } phase_t;

   phase_t ph[5] = '{
      '{n: 40,  p_ce: 100, p_chg: 0,  p_rdy: 100, p_ack: 100},  // streaming
      '{n: 20,  p_ce: 100, p_chg: 0,  p_rdy: 0,   p_ack: 100},  // backpressure
      '{n: 250, p_ce: 90,  p_chg: 15, p_rdy: 60,  p_ack: 40},   // redirect-heavy
      '{n: 250, p_ce: 50,  p_chg: 10, p_rdy: 50,  p_ack: 50},   // ce toggling
      '{n: 400, p_ce: 85,  p_chg: 5,  p_rdy: 70,  p_ack: 60}    // mixed
   };

   task automatic rand_step(input phase_t p);
      step($urandom_range(99) < p.p_ce,
           $urandom_range(99) < p.p_chg,
           $urandom & 32'h0000_0FFC,
           $urandom_range(99) < p.p_rdy,
           ($urandom_range(99) < p.p_ack) && m_busy);
   endtask

   initial begin
      f_rst         = 1'b0;
      f_i_ce        = 1'b0;
      f_i_change_pc = 1'b0;
      f_i_pc        = '0;
      f_i_ready     = 1'b0;
      f_i_mem_ack   = 1'b0;
      f_i_mem_instr = '0;
      model_reset();
      repeat (2) @(negedge f_clk);
      check_zero("rst");
      f_rst = 1'b1;

      for (int p = 0; p < 5; p++) begin
         for (int i = 0; i < ph[p].n; i++)
            rand_step(ph[p]);
         if (p == 1) begin
            check_eq("bp_count", 64'(f_o_count), 64'(DEPTH));
            check_eq("bp_req", 64'(f_o_mem_req), 64'd0);
            step(1'b1, 1'b0, '0, 1'b1, 1'b0);
            check_eq("bp_reissue", 64'(f_o_mem_req), 64'd1);
            step(1'b1, 1'b0, '0, 1'b0, 1'b1);
            step(1'b1, 1'b0, '0, 1'b0, 1'b0);
            check_eq("bp_one_only", 64'(f_o_mem_req), 64'd0);
         end
         if (p == 2) begin
            // Redirect during an outstanding request, response arrives later.
            while (!m_busy) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 32'h0000_0800, 1'b0, 1'b0);
            step(1'b1, 1'b0, '0, 1'b0, 1'b0);
            step(1'b1, 1'b0, '0, 1'b0, 1'b1);
            check_eq("drop_empty", 64'(f_o_count), 64'd0);
            step(1'b1, 1'b0, '0, 1'b0, 1'b0);
            check_eq("drop_newaddr", 64'(f_o_mem_addr), 64'h800);
         end
      end

      // Asynchronous reset between clock edges with a request in flight.
      while (!m_busy) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      #2 f_rst = 1'b0;
      #1 check_zero("arst");
      model_reset();
      @(negedge f_clk);
      f_rst = 1'b1;
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);  // stale ack while idle
      check_eq("stale_count", 64'(f_o_count), 64'd0);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      check_eq("first_addr", 64'(f_o_mem_addr), 64'(RESET_PC));
      for (int i = 0; i < 100; i++)
         rand_step(ph[4]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
